sysbus_ram: RTL and testbench
=============================

SYSBUS_RAM -- requirements
Module: sysbus_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, bus address width; SHALL match the connected SystemBus.
REQ-002 Parameter DATA_WIDTH, default 128, line width in bits; SHALL match the connected SystemBus.
REQ-003 Parameter DEPTH, default 1024, number of lines; SHALL be a power of two.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to rw_ready; legal range 1..15.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 bus  SystemBus.provider  --  provider end of the shared system bus.
REQ-008 bus.rw_valid/rw_addr/rw_we/w_mask/w_data/w_ce  input  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH/1  request fields.
REQ-009 bus.rw_ready/r_data  output  1/DATA_WIDTH  completion pulse and line data.
REQ-010 bus.inv_valid/inv_addr  output  1/ADDR_WIDTH  invalidation request; bus.inv_ready input 1 user acknowledge.

Function
REQ-011 Line index SHALL be rw_addr[OFF +: log2(DEPTH)], with OFF = log2(DATA_WIDTH/8); offset bits and bits above the index are ignored, so addresses alias modulo DEPTH lines.
REQ-012 The FSM SHALL have states IDLE, BUSY, RESP and INV, with one request outstanding at most.
REQ-013 In IDLE with rw_valid=1, the block SHALL latch addr, we, mask, data and ce, load the counter with LATENCY-1, and go to RESP if LATENCY=1, else to BUSY.
REQ-014 BUSY SHALL decrement the counter and go to RESP on the edge where the counter equals 1.
REQ-015 RESP SHALL last exactly one cycle with rw_ready=1, so rw_ready rises LATENCY cycles after the acceptance edge.
REQ-016 Read: r_data during RESP SHALL equal the stored line.
REQ-017 Write: bytes with w_mask[i]=1 SHALL be replaced on the RESP-exit edge, and r_data during RESP SHALL equal the merged line.
REQ-018 A write with all-zero mask SHALL complete normally with storage unchanged.
REQ-019 Outside RESP, rw_ready SHALL be 0 and r_data SHALL hold its last value.
REQ-020 User contract: rw_valid and request fields stay stable until rw_ready; rw_valid drops in the cycle after rw_ready.
REQ-021 Input changes while in BUSY or RESP SHALL be ignored.
REQ-022 After RESP, the FSM SHALL go to INV if the latched we=1 and ce=1, else to IDLE.
REQ-023 A read with ce=1 SHALL NOT invalidate.
REQ-024 In INV, inv_valid SHALL be 1 and inv_addr SHALL equal the latched addr with offset bits cleared.
REQ-025 INV SHALL return to IDLE on the edge where inv_ready=1; if inv_ready is already 1 on entry, inv_valid lasts exactly one cycle.
REQ-026 rw_valid asserted during INV SHALL wait; it is accepted only in IDLE, which gives a one-cycle turnaround minimum.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 rst_n=0 SHALL force IDLE, counter 0, rw_ready=0, r_data=0, inv_valid=0 and inv_addr=0 immediately, regardless of clk.
REQ-029 Reset mid-operation SHALL abort the transaction; a pending write SHALL NOT commit, and no invalidation SHALL be issued.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package sysbus_pkg SHALL hold the FSM state enum and the LINE_OFF_BITS constant function, for reuse by the L1i/L1d user-side controllers.
REQ-032 Storage SHALL be a sub-module sysbus_ram_array: single-port, DEPTH x DATA_WIDTH, per-byte write enable, combinational read, no reset.

Verification
REQ-033 Read latency: LATENCY=2, write line 0x10 = 0x00112233_44556677_8899AABB_CCDDEEFF, then read 0x100 -> rw_ready 2 cycles after acceptance, r_data equals that value.
REQ-034 Masked write: mask 0x000F, data all 0xFF over a line of 0 -> line reads 0x...0000_FFFFFFFF.
REQ-035 Aliasing: with DEPTH=1024, a write to 0x4000 followed by a read of 0x0 -> same data; offsets 0x104 and 0x100 also alias.
REQ-036 Invalidation: write 0x12345678 with ce=1 and inv_ready held 0 for 3 cycles -> inv_valid high 4 cycles, inv_addr=0x12345670; a rw_valid raised during INV is accepted only after.
REQ-037 LATENCY=1 with back-to-back reads, rw_valid re-raised one cycle after the drop -> each rw_ready comes 1 cycle after acceptance, no lost or duplicate pulse.
REQ-038 Reset: rst_n low in BUSY of a write with ce=1 -> outputs 0 asynchronously, a later read shows the old data, no inv_valid.

Source files
------------

// File: rtl/sysbus_pkg.sv
// Shared SystemBus definitions: provider FSM states and line-offset helper,
// also used by the L1i/L1d user-side controllers.
package sysbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    INV  = 2'd3
  } state_t;

  // Number of byte-offset address bits inside one bus line.
  function automatic int unsigned LINE_OFF_BITS(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/sysbus_if.sv
// Shared system bus: one read/write request channel plus an invalidation
// channel from the provider back to the users.
interface SystemBus #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128
);

  logic                      rw_valid;
  logic [ADDR_WIDTH-1:0]     rw_addr;
  logic                      rw_we;
  logic [DATA_WIDTH/8-1:0]   w_mask;
  logic [DATA_WIDTH-1:0]     w_data;
  logic                      w_ce;
  logic                      rw_ready;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      inv_valid;
  logic [ADDR_WIDTH-1:0]     inv_addr;
  logic                      inv_ready;

  modport provider (
    input  rw_valid, rw_addr, rw_we, w_mask, w_data, w_ce, inv_ready,
    output rw_ready, r_data, inv_valid, inv_addr
  );

  modport user (
    output rw_valid, rw_addr, rw_we, w_mask, w_data, w_ce, inv_ready,
    input  rw_ready, r_data, inv_valid, inv_addr
  );

endinterface

// File: rtl/sysbus_ram_array.sv
// Single-port line storage: per-byte write enable, combinational read,
// contents survive reset.
module sysbus_ram_array #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                        clk,
  input  logic [$clog2(DEPTH)-1:0]    addr,
  input  logic [DATA_WIDTH/8-1:0]     be,
  input  logic [DATA_WIDTH-1:0]       wdata,
  output logic [DATA_WIDTH-1:0]       rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sysbus_ram.sv
// SystemBus RAM provider: fixed-latency line read/write with optional
// invalidation broadcast after cache-evicting (ce) writes.
module sysbus_ram
  import sysbus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  SystemBus.provider bus
);

  localparam int unsigned OFF   = LINE_OFF_BITS(DATA_WIDTH);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 4;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   we_q;
  logic                   ce_q;
  logic [BYTES-1:0]       mask_q;
  logic [DATA_WIDTH-1:0]  data_q;

  logic                   rw_ready_q;
  logic [DATA_WIDTH-1:0]  r_data_q;
  logic                   inv_valid_q;
  logic [ADDR_WIDTH-1:0]  inv_addr_q;

  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_we;
  logic [BYTES-1:0]       sel_mask;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [IDX_W-1:0]       arr_addr;
  logic [BYTES-1:0]       arr_be;
  logic [DATA_WIDTH-1:0]  rd_line;
  logic [DATA_WIDTH-1:0]  merged;

  // In IDLE the live request drives the array so LATENCY=1 can respond on the accept edge.
  always_comb begin
    sel_addr = addr_q;
    sel_we   = we_q;
    sel_mask = mask_q;
    sel_data = data_q;
    if (state == IDLE) begin
      sel_addr = bus.rw_addr;
      sel_we   = bus.rw_we;
      sel_mask = bus.w_mask;
      sel_data = bus.w_data;
    end
  end

  assign arr_addr = sel_addr[OFF +: IDX_W];
  assign arr_be   = (state == RESP && we_q) ? mask_q : '0;

  // Line as it will look after the write commits; equals stored line for reads.
  always_comb begin
    merged = rd_line;
    if (sel_we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (sel_mask[i]) merged[i*8 +: 8] = sel_data[i*8 +: 8];
      end
    end
  end

  sysbus_ram_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .addr  (arr_addr),
    .be    (arr_be),
    .wdata (data_q),
    .rdata (rd_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      ce_q        <= 1'b0;
      mask_q      <= '0;
      data_q      <= '0;
      rw_ready_q  <= 1'b0;
      r_data_q    <= '0;
      inv_valid_q <= 1'b0;
      inv_addr_q  <= '0;
    end else begin
      rw_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.rw_valid) begin
            addr_q <= bus.rw_addr;
            we_q   <= bus.rw_we;
            ce_q   <= bus.w_ce;
            mask_q <= bus.w_mask;
            data_q <= bus.w_data;
            cnt    <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state      <= RESP;
              rw_ready_q <= 1'b1;
              r_data_q   <= merged;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state      <= RESP;
            rw_ready_q <= 1'b1;
            r_data_q   <= merged;
          end
        end
        RESP: begin
          if (we_q && ce_q) begin
            state       <= INV;
            inv_valid_q <= 1'b1;
            inv_addr_q  <= {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          end else begin
            state <= IDLE;
          end
        end
        INV: begin
          if (bus.inv_ready) begin
            state       <= IDLE;
            inv_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rw_ready  = rw_ready_q;
  assign bus.r_data    = r_data_q;
  assign bus.inv_valid = inv_valid_q;
  assign bus.inv_addr  = inv_addr_q;

endmodule

// File: tb/tb_sysbus_ram.sv
// Directed bench for sysbus_ram: a LATENCY=2 instance driven from a vector
// table plus invalidation/reset sequences, and a LATENCY=1 instance for back-to-back reads.
module tb_sysbus_ram;

  logic clk;
  logic rst_n;

  SystemBus #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus2 ();
  SystemBus #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus1 ();

  sysbus_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .DEPTH(1024), .LATENCY(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  sysbus_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(128), .DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses1 = 0;

  always @(negedge clk) if (bus1.rw_ready === 1'b1) pulses1++;

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [15:0]  mask;
    logic [127:0] data;
    logic         ce;
    logic [127:0] exp;
    logic         exp_inv;
  } vec_t;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] D3 = 128'hCAFEF00D_11112222_33334444_55556666;
  localparam logic [127:0] D4 = 128'h0BADC0DE_A5A5A5A5_5A5A5A5A_76543210;
  localparam logic [127:0] D5 = 128'h13579BDF_2468ACE0_FEDCBA98_01020304;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] D1_HI = 128'hFFFFFFFF_44556677_8899AABB_CCDDEEFF;

  vec_t vecs[14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn2(input logic [31:0] addr, input logic we, input logic [15:0] mask,
                      input logic [127:0] data, input logic ce,
                      output int lat, output logic [127:0] rd, output logic rdy_after);
    @(negedge clk);
    bus2.rw_addr  = addr;
    bus2.rw_we    = we;
    bus2.w_mask   = mask;
    bus2.w_data   = data;
    bus2.w_ce     = ce;
    bus2.rw_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus2.rw_ready !== 1'b1 && lat < 20);
    rd = bus2.r_data;
    @(posedge clk); #1;
    bus2.rw_valid = 1'b0;
    rdy_after = bus2.rw_ready;
  endtask

  task automatic txn1(input logic [31:0] addr, input logic we, input logic [127:0] data,
                      output int lat, output logic [127:0] rd, output logic rdy_after);
    @(negedge clk);
    bus1.rw_addr  = addr;
    bus1.rw_we    = we;
    bus1.w_mask   = 16'hFFFF;
    bus1.w_data   = data;
    bus1.w_ce     = 1'b0;
    bus1.rw_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus1.rw_ready !== 1'b1 && lat < 20);
    rd = bus1.r_data;
    @(posedge clk); #1;
    bus1.rw_valid = 1'b0;
    rdy_after = bus1.rw_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int           lat;
    int           inv_cycles;
    logic [127:0] rd;
    logic         rdy;
    logic         early;

    vecs[0]  = '{32'h0000_0100, 1'b1, 16'hFFFF, D1,   1'b0, D1,    1'b0};
    vecs[1]  = '{32'h0000_0100, 1'b0, 16'h0000, '0,   1'b0, D1,    1'b0};
    vecs[2]  = '{32'h0000_0104, 1'b0, 16'h0000, '0,   1'b0, D1,    1'b0};
    vecs[3]  = '{32'h0000_0200, 1'b1, 16'hFFFF, '0,   1'b0, '0,    1'b0};
    vecs[4]  = '{32'h0000_0200, 1'b1, 16'h000F, ONES, 1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 1'b0};
    vecs[5]  = '{32'h0000_0200, 1'b0, 16'h0000, '0,   1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 1'b0};
    vecs[6]  = '{32'h0000_4000, 1'b1, 16'hFFFF, D2,   1'b0, D2,    1'b0};
    vecs[7]  = '{32'h0000_0000, 1'b0, 16'h0000, '0,   1'b0, D2,    1'b0};
    vecs[8]  = '{32'h0000_0000, 1'b1, 16'h0000, {8{16'hAAAA}}, 1'b0, D2, 1'b0};
    vecs[9]  = '{32'h0000_0008, 1'b0, 16'h0000, '0,   1'b0, D2,    1'b0};
    vecs[10] = '{32'h0000_0100, 1'b1, 16'hF000, ONES, 1'b0, D1_HI, 1'b0};
    vecs[11] = '{32'h0000_010C, 1'b0, 16'h0000, '0,   1'b0, D1_HI, 1'b0};
    vecs[12] = '{32'h1234_5678, 1'b1, 16'hFFFF, D3,   1'b1, D3,    1'b1};
    vecs[13] = '{32'h1234_567C, 1'b0, 16'h0000, '0,   1'b1, D3,    1'b0};

    bus2.rw_valid = 1'b0; bus2.rw_addr = '0; bus2.rw_we = 1'b0; bus2.w_mask = '0;
    bus2.w_data = '0; bus2.w_ce = 1'b0; bus2.inv_ready = 1'b1;
    bus1.rw_valid = 1'b0; bus1.rw_addr = '0; bus1.rw_we = 1'b0; bus1.w_mask = '0;
    bus1.w_data = '0; bus1.w_ce = 1'b0; bus1.inv_ready = 1'b1;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_rw_ready",  128'(bus2.rw_ready),  128'd0);
    check("reset_r_data",    bus2.r_data,          128'd0);
    check("reset_inv_valid", 128'(bus2.inv_valid), 128'd0);
    check("reset_inv_addr",  128'(bus2.inv_addr),  128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Table: latency, data, single-cycle ready, held r_data, invalidation.
    foreach (vecs[i]) begin
      txn2(vecs[i].addr, vecs[i].we, vecs[i].mask, vecs[i].data, vecs[i].ce, lat, rd, rdy);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'd2);
      check($sformatf("vec%0d_r_data", i), rd, vecs[i].exp);
      check($sformatf("vec%0d_ready_pulse", i), 128'(rdy), 128'd0);
      check($sformatf("vec%0d_r_data_hold", i), bus2.r_data, vecs[i].exp);
      check($sformatf("vec%0d_inv_valid", i), 128'(bus2.inv_valid), 128'(vecs[i].exp_inv));
      if (vecs[i].exp_inv) begin
        check($sformatf("vec%0d_inv_addr", i), 128'(bus2.inv_addr),
              128'(vecs[i].addr & 32'hFFFF_FFF0));
        @(posedge clk); #1;
        check($sformatf("vec%0d_inv_one_cycle", i), 128'(bus2.inv_valid), 128'd0);
      end
    end

    // Invalidation held off three cycles while a read waits behind it.
    bus2.inv_ready = 1'b0;
    txn2(32'h1234_5678, 1'b1, 16'hFFFF, D5, 1'b1, lat, rd, rdy);
    check("inv_write_latency", 128'(lat), 128'd2);
    check("inv_write_r_data", rd, D5);
    bus2.rw_addr  = 32'h1234_5670;
    bus2.rw_we    = 1'b0;
    bus2.w_ce     = 1'b0;
    bus2.rw_valid = 1'b1;
    inv_cycles = 0;
    early = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus2.inv_valid !== 1'b1) break;
      inv_cycles++;
      if (k == 0) check("inv_hold_addr", 128'(bus2.inv_addr), 128'h1234_5670);
      if (bus2.rw_ready === 1'b1) early = 1'b1;
      if (inv_cycles == 4) bus2.inv_ready = 1'b1;
      @(posedge clk); #1;
    end
    check("inv_hold_cycles", 128'(inv_cycles), 128'd4);
    check("inv_no_early_accept", 128'(early), 128'd0);
    lat = 0;
    while (bus2.rw_ready !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("inv_wait_read_latency", 128'(lat), 128'd2);
    check("inv_wait_read_data", bus2.r_data, D5);
    @(posedge clk); #1;
    bus2.rw_valid = 1'b0;

    // LATENCY=1: write then back-to-back reads with one idle edge between.
    txn1(32'h0000_0050, 1'b1, D4, lat, rd, rdy);
    check("l1_write_latency", 128'(lat), 128'd1);
    check("l1_write_r_data", rd, D4);
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      txn1(32'h0000_0050, 1'b0, '0, lat, rd, rdy);
      check($sformatf("l1_read%0d_latency", r), 128'(lat), 128'd1);
      check($sformatf("l1_read%0d_r_data", r), rd, D4);
      check($sformatf("l1_read%0d_ready_pulse", r), 128'(rdy), 128'd0);
    end
    @(negedge clk);
    check("l1_pulse_count", 128'(pulses1), 128'd4);

    // Reset in BUSY of a ce write: async clear, no commit, no invalidation.
    @(negedge clk);
    bus2.rw_addr  = 32'h0000_0100;
    bus2.rw_we    = 1'b1;
    bus2.w_mask   = 16'hFFFF;
    bus2.w_data   = {16{8'h77}};
    bus2.w_ce     = 1'b1;
    bus2.rw_valid = 1'b1;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    check("midreset_rw_ready",  128'(bus2.rw_ready),  128'd0);
    check("midreset_r_data",    bus2.r_data,          128'd0);
    check("midreset_inv_valid", 128'(bus2.inv_valid), 128'd0);
    check("midreset_inv_addr",  128'(bus2.inv_addr),  128'd0);
    bus2.rw_valid = 1'b0;
    bus2.w_ce     = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    early = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus2.inv_valid !== 1'b0 || bus2.rw_ready !== 1'b0) early = 1'b1;
    end
    check("midreset_quiet", 128'(early), 128'd0);
    txn2(32'h0000_0100, 1'b0, 16'h0000, '0, 1'b0, lat, rd, rdy);
    check("midreset_old_data", rd, D1_HI);
    check("midreset_read_latency", 128'(lat), 128'd2);
    check("midreset_no_inv", 128'(bus2.inv_valid), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
